fetch_controller: RTL and testbench

//  Sequences instruction fetch and data-memory access for the CPU: drives PC reset/load, memory address select,

---
 rtl/fetch_controller_if.sv | 34 +++
 rtl/fetch_controller.sv | 174 +++++++++++++++++
 tb/tb_fetch_controller.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Bundles the control/status lines between the fetch controller and the datapath/execute FSM.
// master: fetch_controller drives the PC/IR enables, the memory command and the execute handshake.
// slave: datapath/execute side, which supplies the opcode and the execute-side requests.
interface fetch_controller_if #(
  parameter int CNT_W = 16
);
  // Inputs to the controller.
  logic [2:0]       ir_opcode;
  logic             exec_done;
  logic             exec_mem_req;
  logic             exec_mem_we;
  // Outputs from the controller.
  logic [1:0]       mem_cmd;
  logic             addr_sel;
  logic             load_ir;
  logic             load_pc;
  logic             reset_pc;
  logic             exec_start;
  logic             exec_mem_ack;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    input  ir_opcode, exec_done, exec_mem_req, exec_mem_we,
    output mem_cmd, addr_sel, load_ir, load_pc, reset_pc,
           exec_start, exec_mem_ack, halted, fetch_count
  );

  modport slave (
    output ir_opcode, exec_done, exec_mem_req, exec_mem_we,
    input  mem_cmd, addr_sel, load_ir, load_pc, reset_pc,
           exec_start, exec_mem_ack, halted, fetch_count
  );
endinterface

// File: rtl/fetch_controller.sv
// Purpose: sequences instruction fetch and execute-side data accesses on the shared memory port.
// Latency: load_ir MEM_LAT cycles after IF_ISSUE, exec_start 2 cycles later; data ack MEM_LAT cycles after issue.
// Backpressure: execute FSM holds exec_mem_req until exec_mem_ack; exec_done/exec_mem_req ignored outside EXEC.
module fetch_controller #(
  parameter int         MEM_LAT = 1,
  parameter int         CNT_W   = 16,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input logic               clk,
  input logic               reset,
  fetch_controller_if.master bus
);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  // Wait counter only needs to hold MEM_LAT-1; keep at least one bit.
  localparam int            CW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_RESET_PC,
    S_IF_ISSUE,
    S_IF_WAIT,
    S_UPDATE_PC,
    S_DISPATCH,
    S_EXEC,
    S_DATA_ISSUE,
    S_DATA_WAIT,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic             we_q, we_d;

  logic [1:0]       mem_cmd;
  logic             addr_sel;
  logic             load_ir;
  logic             load_pc;
  logic             reset_pc;
  logic             exec_start;
  logic             exec_mem_ack;
  logic             halted;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // State, wait counter, retired-fetch counter and latched write flag; reset from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RESET_PC;
      cnt_q       <= '0;
      fetch_cnt_q <= '0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      we_q        <= we_d;
    end
  end

  // Next-state logic and Moore output decode from the registered state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_cnt_d  = fetch_cnt_q;
    we_d         = we_q;
    mem_cmd      = CMD_NONE;
    addr_sel     = 1'b0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    reset_pc     = 1'b0;
    exec_start   = 1'b0;
    exec_mem_ack = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_RESET_PC: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        addr_sel = 1'b1;
        state_d  = S_IF_ISSUE;
      end

      S_IF_ISSUE: begin
        addr_sel = 1'b1;
        mem_cmd  = CMD_READ;
        cnt_d    = LAT_M1;
        state_d  = S_IF_WAIT;
      end

      S_IF_WAIT: begin
        addr_sel = 1'b1;
        mem_cmd  = CMD_READ;
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Read data is valid this cycle: capture it into IR.
          load_ir = 1'b1;
          state_d = S_UPDATE_PC;
        end
      end

      S_UPDATE_PC: begin
        // IR was loaded last cycle, so the opcode is already decoded here.
        load_pc     = 1'b1;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        state_d     = (bus.ir_opcode == HALT_OP) ? S_HALT : S_DISPATCH;
      end

      S_DISPATCH: begin
        exec_start = 1'b1;
        state_d    = S_EXEC;
      end

      S_EXEC: begin
        // Completion takes priority; a simultaneous data request is dropped.
        if (bus.exec_done) begin
          state_d = S_IF_ISSUE;
        end else if (bus.exec_mem_req) begin
          we_d    = bus.exec_mem_we;
          state_d = S_DATA_ISSUE;
        end
      end

      S_DATA_ISSUE: begin
        mem_cmd = we_q ? CMD_WRITE : CMD_READ;
        cnt_d   = LAT_M1;
        state_d = S_DATA_WAIT;
      end

      S_DATA_WAIT: begin
        // Writes stay asserted at the same address; repeating them is harmless.
        mem_cmd = we_q ? CMD_WRITE : CMD_READ;
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          exec_mem_ack = 1'b1;
          state_d      = S_EXEC;
        end
      end

      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end

      default: begin
        state_d = S_RESET_PC;
      end
    endcase
  end

  assign bus.mem_cmd      = mem_cmd;
  assign bus.addr_sel     = addr_sel;
  assign bus.load_ir      = load_ir;
  assign bus.load_pc      = load_pc;
  assign bus.reset_pc     = reset_pc;
  assign bus.exec_start   = exec_start;
  assign bus.exec_mem_ack = exec_mem_ack;
  assign bus.halted       = halted;
  assign bus.fetch_count  = fetch_cnt_q;

  // The command encoding 2'b11 is never produced.
  a_cmd_legal: assert property (@(posedge clk) disable iff (reset) mem_cmd != 2'b11);

  // Dispatch and data acknowledge belong to different states and never coincide.
  a_start_ack_excl: assert property (@(posedge clk) disable iff (reset) !(exec_start && exec_mem_ack));

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, hand-written corner sequences, randomized run vs model.
// Two instances (MEM_LAT=1 and MEM_LAT=3) share stimulus; outputs sampled 1ns after the falling edge.
// Inputs are driven on the falling edge and are not throttled by the design.
module tb_fetch_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       done = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [2:0] op = 3'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_controller_if #(.CNT_W(16)) if1 ();
  fetch_controller_if #(.CNT_W(16)) if3 ();

  assign if1.ir_opcode    = op;
  assign if1.exec_done    = done;
  assign if1.exec_mem_req = req;
  assign if1.exec_mem_we  = we;
  assign if3.ir_opcode    = op;
  assign if3.exec_done    = done;
  assign if3.exec_mem_req = req;
  assign if3.exec_mem_we  = we;

  fetch_controller #(.MEM_LAT(1), .CNT_W(16), .HALT_OP(3'b111)) dut1 (
    .clk   (clk),
    .reset (rst),
    .bus   (if1.master)
  );

  fetch_controller #(.MEM_LAT(3), .CNT_W(16), .HALT_OP(3'b111)) dut3 (
    .clk   (clk),
    .reset (rst),
    .bus   (if3.master)
  );

  // Output vector: {mem_cmd, addr_sel, load_ir, load_pc, reset_pc, exec_start, exec_mem_ack, halted}
  function automatic logic [8:0] ov(input logic [1:0] cmd, input logic asel, input logic lir,
                                    input logic lpc, input logic rpc, input logic st,
                                    input logic ack, input logic hlt);
    return {cmd, asel, lir, lpc, rpc, st, ack, hlt};
  endfunction

  function automatic logic [24:0] get_out(input int sel);
    if (sel == 1)
      return {if1.mem_cmd, if1.addr_sel, if1.load_ir, if1.load_pc, if1.reset_pc,
              if1.exec_start, if1.exec_mem_ack, if1.halted, if1.fetch_count};
    return {if3.mem_cmd, if3.addr_sel, if3.load_ir, if3.load_pc, if3.reset_pc,
            if3.exec_start, if3.exec_mem_ack, if3.halted, if3.fetch_count};
  endfunction

  task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic d, input logic q, input logic w, input logic [2:0] o);
    @(negedge clk);
    rst = r; done = d; req = q; we = w; op = o;
    #1;
  endtask

  // ---------------- reference model: a schedule of upcoming output cycles ----------------
  typedef struct packed {
    logic [8:0] o;
    logic       upd;   // cycle in which the opcode is inspected and the fetch retires
  } ent_t;

  ent_t        sched[$];
  bit          hm;
  logic [15:0] fcm;

  task automatic push_fetch(input int lat);
    sched.push_back('{o: ov(2'b01, 1, 0, 0, 0, 0, 0, 0), upd: 1'b0});
    for (int i = 0; i < lat - 1; i++)
      sched.push_back('{o: ov(2'b01, 1, 0, 0, 0, 0, 0, 0), upd: 1'b0});
    sched.push_back('{o: ov(2'b01, 1, 1, 0, 0, 0, 0, 0), upd: 1'b0});
    sched.push_back('{o: ov(2'b00, 0, 0, 1, 0, 0, 0, 0), upd: 1'b1});
  endtask

  task automatic push_data(input int lat, input logic w);
    logic [1:0] cmd;
    cmd = w ? 2'b10 : 2'b01;
    for (int i = 0; i < lat; i++)
      sched.push_back('{o: ov(cmd, 0, 0, 0, 0, 0, 0, 0), upd: 1'b0});
    sched.push_back('{o: ov(cmd, 0, 0, 0, 0, 0, 1, 0), upd: 1'b0});
  endtask

  function automatic logic [24:0] model_exp();
    logic [8:0] o;
    if (sched.size() > 0) o = sched[0].o;
    else if (hm)          o = ov(0, 0, 0, 0, 0, 0, 0, 1);
    else                  o = 9'd0;
    return {o, fcm};
  endfunction

  task automatic model_step(input logic r, input logic d, input logic q, input logic w,
                            input logic [2:0] o, input int lat);
    ent_t e;
    if (r) begin
      sched.delete();
      sched.push_back('{o: ov(0, 1, 0, 1, 1, 0, 0, 0), upd: 1'b0});
      push_fetch(lat);
      hm  = 1'b0;
      fcm = 16'd0;
    end else if (sched.size() > 0) begin
      e = sched.pop_front();
      if (e.upd) begin
        fcm = fcm + 16'd1;
        if (o == 3'b111) hm = 1'b1;
        else sched.push_back('{o: ov(0, 0, 0, 0, 0, 1, 0, 0), upd: 1'b0});
      end
    end else if (!hm) begin
      if (d)      push_fetch(lat);
      else if (q) push_data(lat, w);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       r, d, q, w;
    logic [2:0] o;
    bit         c;
    logic [8:0] eo;
    logic [15:0] efc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic d, input logic q, input logic w, input logic [2:0] o,
                     input bit c, input logic [8:0] eo, input logic [15:0] efc);
    vec_t v;
    v.r = r; v.d = d; v.q = q; v.w = w; v.o = o; v.c = c; v.eo = eo; v.efc = efc;
    tbl.push_back(v);
  endtask

  initial begin
    logic [8:0] v_rst, v_ifi, v_ifw, v_ifr, v_upd, v_dsp, v_ex, v_hlt;
    logic [24:0] exp;
    bit found;
    logic r, d, q, w;
    logic [2:0] o;

    v_rst = ov(0, 1, 0, 1, 1, 0, 0, 0);
    v_ifi = ov(1, 1, 0, 0, 0, 0, 0, 0);
    v_ifr = ov(1, 1, 0, 0, 0, 0, 0, 0);
    v_ifw = ov(1, 1, 1, 0, 0, 0, 0, 0);
    v_upd = ov(0, 0, 0, 1, 0, 0, 0, 0);
    v_dsp = ov(0, 0, 0, 0, 0, 1, 0, 0);
    v_ex  = 9'd0;
    v_hlt = ov(0, 0, 0, 0, 0, 0, 0, 1);

    //  r  d  q  w  op    chk  expected                      fc
    add(1, 0, 0, 0, 3'd0, 0, v_ex,                          16'd0);
    add(1, 0, 0, 0, 3'd0, 1, v_rst,                         16'd0);
    add(0, 1, 1, 0, 3'd0, 1, v_rst,                         16'd0);
    add(0, 1, 0, 0, 3'd0, 1, v_ifi,                         16'd0);
    add(0, 0, 1, 0, 3'd0, 1, v_ifw,                         16'd0);
    add(0, 0, 0, 0, 3'd0, 1, v_upd,                         16'd0);
    add(0, 0, 0, 0, 3'd0, 1, v_dsp,                         16'd1);
    add(0, 0, 0, 0, 3'd0, 1, v_ex,                          16'd1);
    add(0, 0, 0, 0, 3'd0, 1, v_ex,                          16'd1);
    add(0, 1, 0, 0, 3'd0, 1, v_ex,                          16'd1);
    add(0, 0, 0, 0, 3'd0, 1, v_ifi,                         16'd1);
    add(0, 0, 0, 0, 3'd3, 1, v_ifw,                         16'd1);
    add(0, 0, 0, 0, 3'd3, 1, v_upd,                         16'd1);
    add(0, 0, 0, 0, 3'd0, 1, v_dsp,                         16'd2);
    add(0, 0, 1, 1, 3'd0, 1, v_ex,                          16'd2);
    add(0, 0, 0, 0, 3'd0, 1, ov(2, 0, 0, 0, 0, 0, 0, 0),    16'd2);
    add(0, 0, 0, 0, 3'd0, 1, ov(2, 0, 0, 0, 0, 0, 1, 0),    16'd2);
    add(0, 0, 1, 0, 3'd0, 1, v_ex,                          16'd2);
    add(0, 0, 1, 1, 3'd0, 1, ov(1, 0, 0, 0, 0, 0, 0, 0),    16'd2);
    add(0, 1, 0, 0, 3'd0, 1, ov(1, 0, 0, 0, 0, 0, 1, 0),    16'd2);
    add(0, 1, 1, 1, 3'd0, 1, v_ex,                          16'd2);
    add(0, 0, 0, 0, 3'd0, 1, v_ifi,                         16'd2);
    add(0, 0, 0, 0, 3'd7, 1, v_ifw,                         16'd2);
    add(0, 0, 0, 0, 3'd7, 1, v_upd,                         16'd2);
    add(0, 0, 0, 0, 3'd0, 1, v_hlt,                         16'd3);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].d, tbl[i].q, tbl[i].w, tbl[i].o);
      if (tbl[i].c) chk($sformatf("vec%0d", i), get_out(1), {tbl[i].eo, tbl[i].efc});
    end

    // Halted: stays put for 20 cycles despite execute-side activity.
    for (int i = 0; i < 20; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)));
      chk("halt_hold", get_out(1), {v_hlt, 16'd3});
    end

    // MEM_LAT=3 fetch timing, then reset during a data wait.
    drive(1, 0, 0, 0, 3'd0);
    drive(1, 0, 0, 0, 3'd0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      drive(0, 0, 0, 0, 3'd0);
      if (get_out(3)[24:16] == v_ifi) found = 1'b1;
    end
    chk("lat3_find_issue", 25'(found), 25'd1);
    drive(0, 0, 0, 0, 3'd0); chk("lat3_wait1", get_out(3), {v_ifr, 16'd0});
    drive(0, 0, 0, 0, 3'd0); chk("lat3_wait2", get_out(3), {v_ifr, 16'd0});
    drive(0, 0, 0, 0, 3'd0); chk("lat3_load_ir", get_out(3), {v_ifw, 16'd0});
    drive(0, 0, 0, 0, 3'd0); chk("lat3_update", get_out(3), {v_upd, 16'd0});
    drive(0, 0, 0, 0, 3'd0); chk("lat3_dispatch", get_out(3), {v_dsp, 16'd1});
    drive(0, 0, 1, 0, 3'd0); chk("lat3_exec", get_out(3), {v_ex, 16'd1});
    drive(0, 0, 0, 0, 3'd0); chk("lat3_d_issue", get_out(3), {ov(1, 0, 0, 0, 0, 0, 0, 0), 16'd1});
    drive(0, 0, 0, 0, 3'd0); chk("lat3_d_wait", get_out(3), {ov(1, 0, 0, 0, 0, 0, 0, 0), 16'd1});
    drive(1, 0, 0, 0, 3'd0); chk("lat3_d_wait_rst", get_out(3), {ov(1, 0, 0, 0, 0, 0, 0, 0), 16'd1});
    drive(0, 0, 0, 0, 3'd0); chk("rst_in_data_wait", get_out(3), {v_rst, 16'd0});

    // Randomized run against the schedule model, once per latency.
    for (int s = 0; s < 2; s++) begin
      int sel;
      sel = (s == 0) ? 1 : 3;
      for (int i = 0; i < 2; i++) begin
        drive(1, 0, 0, 0, 3'd0);
        model_step(1, 0, 0, 0, 3'd0, sel);
      end
      for (int i = 0; i < 2500; i++) begin
        r = ($urandom_range(0, 149) == 0);
        d = ($urandom_range(0, 5) == 0);
        q = ($urandom_range(0, 3) == 0);
        w = 1'($urandom_range(0, 1));
        o = ($urandom_range(0, 19) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        drive(r, d, q, w, o);
        exp = model_exp();
        chk($sformatf("rand_lat%0d_cyc%0d", sel, i), get_out(sel), exp);
        model_step(r, d, q, w, o, sel);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
